// File: rtl/uart_tx.sv
// uart_tx: valid/ack byte source to asynchronous serial frames (start, 8 data LSB first, optional parity, 1-2 stop)
module uart_tx #(
   parameter int CLKS_PER_BIT = 87,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_data_valid,
   output logic       tx_data_ack,
   output logic       txd,
   output logic       tx_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [7:0] sh, sh_n;
   logic txd_n, busy_n, ack_n, tick, par;
   assign tick = cnt == LAST;
   assign par = ^sh ^ (PARITY_ODD != 0);
   // state and registered outputs; reset forces the line idle and abandons any frame
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         sh          <= '0;
         txd         <= 1'b1;
         tx_busy     <= 1'b0;
         tx_data_ack <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         sh          <= sh_n;
         txd         <= txd_n;
         tx_busy     <= busy_n;
         tx_data_ack <= ack_n;
      end
   end
   // next state: baud counter paces every bit, txd only moves on a bit boundary
   always_comb begin
      state_n = state;
      cnt_n   = (state == IDLE || tick) ? '0 : cnt + 1'b1;
      idx_n   = idx;
      sh_n    = sh;
      txd_n   = txd;
      busy_n  = tx_busy;
      ack_n   = 1'b0;
      case (state)
         IDLE: if (tx_data_valid) begin
            sh_n    = tx_data;
            txd_n   = 1'b0;
            busy_n  = 1'b1;
            ack_n   = 1'b1;
            idx_n   = '0;
            state_n = START;
         end
         START: if (tick) begin
            state_n = DATA;
            txd_n   = sh[0];
            idx_n   = '0;
         end
         DATA: if (tick) begin
            if (idx == 3'd7) begin
               state_n = (PARITY_EN != 0) ? PARITY : STOP;
               txd_n   = (PARITY_EN != 0) ? par : 1'b1;
               idx_n   = '0;
            end else begin
               idx_n = idx + 3'd1;
               txd_n = sh[idx_n];
            end
         end
         PARITY: if (tick) begin
            state_n = STOP;
            txd_n   = 1'b1;
            idx_n   = '0;
         end
         STOP: if (tick) begin
            if (idx == 3'(STOP_BITS - 1)) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               idx_n   = '0;
            end else begin
               idx_n = idx + 3'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three framing configurations driven with random traffic and checked every cycle against a frame-level model
module tb_uart_tx;
   localparam int N = 3;
   localparam int CPB[N] = '{4, 5, 3};
   localparam int PE[N]  = '{0, 1, 1};
   localparam int PO[N]  = '{0, 1, 0};
   localparam int SB[N]  = '{1, 2, 1};
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] valid = '0;
   logic [N-1:0] txd, ack, busy;
   logic [7:0] data[N];
   int passed = 0;
   int total = 0;
   int cyc = 0;
   logic mb[N];
   logic et[N];
   logic ea[N];
   int pos[N];
   int flen[N];
   logic [11:0] fb[N];
   always #5 clk = ~clk;
   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clk(clk), .rst(rst), .tx_data(data[0]), .tx_data_valid(valid[0]),
      .tx_data_ack(ack[0]), .txd(txd[0]), .tx_busy(busy[0]));
   uart_tx #(.CLKS_PER_BIT(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .tx_data(data[1]), .tx_data_valid(valid[1]),
      .tx_data_ack(ack[1]), .txd(txd[1]), .tx_busy(busy[1]));
   uart_tx #(.CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
      .clk(clk), .rst(rst), .tx_data(data[2]), .tx_data_valid(valid[2]),
      .tx_data_ack(ack[2]), .txd(txd[2]), .tx_busy(busy[2]));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask
   // bits of one frame in transmission order: start, data LSB first, parity, stops
   function automatic logic [11:0] frame(input logic [7:0] d, input int pe, input int po, input int sb);
      logic [11:0] f = '1;
      int n = 0;
      f[n++] = 1'b0;
      for (int i = 0; i < 8; i++) f[n++] = d[i];
      if (pe != 0) f[n++] = (^d) ^ (po != 0);
      for (int s = 0; s < sb; s++) f[n++] = 1'b1;
      return f;
   endfunction
   task automatic step();
      @(posedge clk);
      cyc++;
      for (int k = 0; k < N; k++) begin
         if (rst) begin
            mb[k] = 1'b0; et[k] = 1'b1; ea[k] = 1'b0;
         end else if (!mb[k]) begin
            ea[k] = valid[k];
            et[k] = !valid[k];
            if (valid[k]) begin
               mb[k]   = 1'b1;
               pos[k]  = 0;
               fb[k]   = frame(data[k], PE[k], PO[k], SB[k]);
               flen[k] = (10 + PE[k] + SB[k] - 1) * CPB[k];
            end
         end else begin
            ea[k] = 1'b0;
            pos[k]++;
            if (pos[k] == flen[k]) begin
               mb[k] = 1'b0; et[k] = 1'b1;
            end else et[k] = fb[k][pos[k] / CPB[k]];
         end
      end
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("txd%0d", k), 32'(txd[k]), 32'(et[k]));
         check($sformatf("ack%0d", k), 32'(ack[k]), 32'(ea[k]));
         check($sformatf("busy%0d", k), 32'(busy[k]), 32'(mb[k]));
      end
   endtask
   initial begin
      for (int k = 0; k < N; k++) begin
         data[k] = 8'h00; mb[k] = 1'b0; et[k] = 1'b1; ea[k] = 1'b0; pos[k] = 0; flen[k] = 0; fb[k] = '1;
      end
      rst = 1'b1;
      valid = '1;
      repeat (3) step();
      rst = 1'b0;
      valid = '1;
      for (int k = 0; k < N; k++) data[k] = 8'h61;
      step();
      valid = '0;
      repeat (70) step();
      for (int i = 0; i < 4000; i++) begin
         rst = (i == 1500) || ($urandom_range(0, 499) == 0);
         for (int k = 0; k < N; k++) begin
            valid[k] = (i >= 2000 && i < 2500) || ($urandom_range(0, 3) != 0);
            data[k]  = 8'($urandom);
         end
         step();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
